fp8_special_resolver: RTL and testbench

Pipelined special-case resolver for the 8-bit FPU. It accepts an operation and two operands over a valid/ready handshake and classifies each operand as NaN, infinity or zero. It produces the final IEEE-style special result (canonical NaN, signed infinity, signed zero) or marks the request for the arithmetic core. It also keeps sticky exception status and a saturating exception counter. It sits between the operand issue logic and the add/sub/mul datapath result mux.

---
 rtl/fp8_special_resolver.sv | 194 +++++++++++++++++++
 tb/tb_fp8_special_resolver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_special_resolver.sv
`default_nettype none
// ============================================================================
// Module      : fp8_special_resolver
// Description : Two-stage special-case resolver for the 8-bit FPU. Classifies
//               operands (NaN / Inf / Zero), produces the final special result
//               or defers to the arithmetic core, and keeps sticky exception
//               status plus a saturating exception counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fp8_special_resolver #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       FP_OPERATION,
    input  logic [7:0]       OP_A,
    input  logic [7:0]       OP_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [7:0]       RESULT,
    output logic             RESULT_IS_SPECIAL,
    output logic [2:0]       FP_EXCE,
    output logic [2:0]       STATUS,
    input  logic             STATUS_CLR,
    output logic [CNT_W-1:0] EXC_COUNT
);

    localparam logic [1:0]       c_OP_ADD        = 2'b00;
    localparam logic [1:0]       c_OP_SUB        = 2'b01;
    localparam logic [1:0]       c_OP_MUL        = 2'b10;
    localparam logic [1:0]       c_OP_RSVD       = 2'b11;
    localparam logic [7:0]       c_CANON_NAN     = 8'h7C;
    localparam logic [6:0]       c_INF_MAG       = 7'h78;
    localparam logic [2:0]       c_FLAG_INVALID  = 3'b001;
    localparam logic [2:0]       c_FLAG_NAN_PROP = 3'b010;
    localparam logic [2:0]       c_FLAG_INF      = 3'b100;
    localparam logic [CNT_W-1:0] c_CNT_MAX       = {CNT_W{1'b1}};

    // Operand classification straight from the request port
    logic w_a_nan, w_a_inf, w_a_zero;
    logic w_b_nan, w_b_inf, w_b_zero;

    assign w_a_nan  = (&OP_A[6:3]) & (|OP_A[2:0]);
    assign w_a_inf  = (&OP_A[6:3]) & ~(|OP_A[2:0]);
    assign w_a_zero = ~(|OP_A[6:0]);
    assign w_b_nan  = (&OP_B[6:3]) & (|OP_B[2:0]);
    assign w_b_inf  = (&OP_B[6:3]) & ~(|OP_B[2:0]);
    assign w_b_zero = ~(|OP_B[6:0]);

    // Stage 1 state: operation, signs and class bits
    logic       r_s1_valid;
    logic [1:0] r_s1_op;
    logic       r_s1_sign_a, r_s1_sign_b;
    logic       r_s1_nan_a, r_s1_inf_a, r_s1_zero_a;
    logic       r_s1_nan_b, r_s1_inf_b, r_s1_zero_b;

    // Stage 2 state: the visible result
    logic       r_s2_valid;
    logic [7:0] r_s2_result;
    logic       r_s2_special;
    logic [2:0] r_s2_exce;

    logic [2:0]       r_status;
    logic [CNT_W-1:0] r_exc_count;

    // Handshake: S2 can take new data when empty or being drained this cycle
    logic w_advance, w_accept, w_xfer;

    assign w_advance = ~r_s2_valid | OUT_READY;
    assign IN_READY  = ~RST & (~r_s1_valid | w_advance);
    assign w_accept  = IN_VALID & IN_READY;
    assign w_xfer    = r_s2_valid & OUT_READY;

    // Decoded operation of the request sitting in stage 1
    logic w_is_add, w_is_sub, w_is_mul;
    logic w_any_nan, w_any_inf, w_invalid, w_inf_sign;

    assign w_is_add  = (r_s1_op == c_OP_ADD);
    assign w_is_sub  = (r_s1_op == c_OP_SUB);
    assign w_is_mul  = (r_s1_op == c_OP_MUL);
    assign w_any_nan = r_s1_nan_a | r_s1_nan_b;
    assign w_any_inf = r_s1_inf_a | r_s1_inf_b;

    // Inf-minus-inf style cancellations and 0*inf have no defined value
    assign w_invalid =
        (w_is_add & r_s1_inf_a & r_s1_inf_b & (r_s1_sign_a ^ r_s1_sign_b)) |
        (w_is_sub & r_s1_inf_a & r_s1_inf_b & ~(r_s1_sign_a ^ r_s1_sign_b)) |
        (w_is_mul & ((r_s1_zero_a & r_s1_inf_b) | (r_s1_inf_a & r_s1_zero_b)));

    // Sign of an infinite result; for sub an infinite B flips sign
    assign w_inf_sign = w_is_mul ? (r_s1_sign_a ^ r_s1_sign_b) :
                        r_s1_inf_a ? r_s1_sign_a :
                        w_is_sub ? ~r_s1_sign_b : r_s1_sign_b;

    logic [7:0] w_result;
    logic       w_special;
    logic [2:0] w_exce;

    // Priority resolution of the special result for the stage-1 request
    always_comb begin
        w_result  = 8'h00;
        w_special = 1'b0;
        w_exce    = 3'b000;
        if (r_s1_op != c_OP_RSVD) begin
            if (w_any_nan) begin
                w_result  = c_CANON_NAN;
                w_special = 1'b1;
                w_exce    = c_FLAG_NAN_PROP;
            end else if (w_invalid) begin
                w_result  = c_CANON_NAN;
                w_special = 1'b1;
                w_exce    = c_FLAG_INVALID;
            end else if (w_any_inf) begin
                w_result  = {w_inf_sign, c_INF_MAG};
                w_special = 1'b1;
                w_exce    = c_FLAG_INF;
            end else if (w_is_mul & (r_s1_zero_a | r_s1_zero_b)) begin
                w_result  = {r_s1_sign_a ^ r_s1_sign_b, 7'h00};
                w_special = 1'b1;
            end
        end
    end

    // Stage 1 capture; empties when its content moves on without a refill
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= 2'b00;
            r_s1_sign_a <= 1'b0;
            r_s1_sign_b <= 1'b0;
            r_s1_nan_a  <= 1'b0;
            r_s1_inf_a  <= 1'b0;
            r_s1_zero_a <= 1'b0;
            r_s1_nan_b  <= 1'b0;
            r_s1_inf_b  <= 1'b0;
            r_s1_zero_b <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid  <= 1'b1;
            r_s1_op     <= FP_OPERATION;
            r_s1_sign_a <= OP_A[7];
            r_s1_sign_b <= OP_B[7];
            r_s1_nan_a  <= w_a_nan;
            r_s1_inf_a  <= w_a_inf;
            r_s1_zero_a <= w_a_zero;
            r_s1_nan_b  <= w_b_nan;
            r_s1_inf_b  <= w_b_inf;
            r_s1_zero_b <= w_b_zero;
        end else if (w_advance) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // Stage 2 capture; holds its result while the output is stalled
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s2_valid   <= 1'b0;
            r_s2_result  <= 8'h00;
            r_s2_special <= 1'b0;
            r_s2_exce    <= 3'b000;
        end else if (w_advance) begin
            r_s2_valid   <= r_s1_valid;
            r_s2_result  <= r_s1_valid ? w_result  : 8'h00;
            r_s2_special <= r_s1_valid & w_special;
            r_s2_exce    <= r_s1_valid ? w_exce    : 3'b000;
        end
    end

    // Sticky status and saturating counter; a clear acts before the update
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_status    <= 3'b000;
            r_exc_count <= '0;
        end else if (STATUS_CLR) begin
            r_status    <= w_xfer ? r_s2_exce : 3'b000;
            r_exc_count <= CNT_W'(w_xfer & (|r_s2_exce));
        end else if (w_xfer) begin
            r_status <= r_status | r_s2_exce;
            if ((|r_s2_exce) && (r_exc_count != c_CNT_MAX)) begin
                r_exc_count <= r_exc_count + CNT_W'(1);
            end
        end
    end

    assign OUT_VALID         = r_s2_valid;
    assign RESULT            = r_s2_result;
    assign RESULT_IS_SPECIAL = r_s2_special;
    assign FP_EXCE           = r_s2_exce;
    assign STATUS            = r_status;
    assign EXC_COUNT         = r_exc_count;

endmodule
`default_nettype wire

// File: tb/tb_fp8_special_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp8_special_resolver
// Description : Self-checking bench for fp8_special_resolver. A queue-based
//               reference model tracks requests in flight, expected results,
//               sticky status and the saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp8_special_resolver;

    localparam int CNT_W = 8;
    localparam logic [1:0] c_ADD = 2'b00;
    localparam logic [1:0] c_SUB = 2'b01;
    localparam logic [1:0] c_MUL = 2'b10;
    localparam logic [1:0] c_RSV = 2'b11;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [1:0]       FP_OPERATION = 2'b00;
    logic [7:0]       OP_A = 8'h00;
    logic [7:0]       OP_B = 8'h00;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [7:0]       RESULT;
    logic             RESULT_IS_SPECIAL;
    logic [2:0]       FP_EXCE;
    logic [2:0]       STATUS;
    logic             STATUS_CLR = 1'b0;
    logic [CNT_W-1:0] EXC_COUNT;

    fp8_special_resolver #(.CNT_W(CNT_W)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .IN_VALID          (IN_VALID),
        .IN_READY          (IN_READY),
        .FP_OPERATION      (FP_OPERATION),
        .OP_A              (OP_A),
        .OP_B              (OP_B),
        .OUT_VALID         (OUT_VALID),
        .OUT_READY         (OUT_READY),
        .RESULT            (RESULT),
        .RESULT_IS_SPECIAL (RESULT_IS_SPECIAL),
        .FP_EXCE           (FP_EXCE),
        .STATUS            (STATUS),
        .STATUS_CLR        (STATUS_CLR),
        .EXC_COUNT         (EXC_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] res;
        logic       spec;
        logic [2:0] exc;
    } res_t;

    typedef struct {
        res_t r;
        int   age;
    } ent_t;

    ent_t q[$];
    int   m_status;
    int   m_count;
    bit   m_valid     = 1'b0;
    bit   m_after_rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_nan(input logic [7:0] x);
        return (x[6:3] == 4'hF) && (x[2:0] != 3'd0);
    endfunction
    function automatic bit is_inf(input logic [7:0] x);
        return (x[6:3] == 4'hF) && (x[2:0] == 3'd0);
    endfunction
    function automatic bit is_zero(input logic [7:0] x);
        return x[6:0] == 7'd0;
    endfunction

    // Reference resolution, written directly from the rule list
    function automatic res_t resolve(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        res_t r;
        logic sa, sb;
        sa = a[7];
        sb = b[7];
        r  = '{res: 8'h00, spec: 1'b0, exc: 3'b000};
        if (op == c_RSV) return r;
        if (is_nan(a) || is_nan(b)) return '{res: 8'h7C, spec: 1'b1, exc: 3'b010};
        if ((op == c_ADD && is_inf(a) && is_inf(b) && sa != sb) ||
            (op == c_SUB && is_inf(a) && is_inf(b) && sa == sb) ||
            (op == c_MUL && ((is_zero(a) && is_inf(b)) || (is_inf(a) && is_zero(b)))))
            return '{res: 8'h7C, spec: 1'b1, exc: 3'b001};
        if (is_inf(a) || is_inf(b)) begin
            logic s;
            if (op == c_MUL)       s = sa ^ sb;
            else if (is_inf(a))    s = sa;
            else if (op == c_SUB)  s = ~sb;
            else                   s = sb;
            return '{res: (s ? 8'hF8 : 8'h78), spec: 1'b1, exc: 3'b100};
        end
        if (op == c_MUL && (is_zero(a) || is_zero(b)))
            return '{res: ((sa ^ sb) ? 8'h80 : 8'h00), spec: 1'b1, exc: 3'b000};
        return r;
    endfunction

    // One clock cycle: check the outputs, drive new inputs, advance the model
    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ordy, input logic clr,
                        input logic rst);
        bit   exp_ov, exp_ir, xfer, acc;
        ent_t e;
        @(negedge CLK);
        if (m_valid) begin
            exp_ov = (q.size() > 0) && (q[0].age >= 1);
            chk("out_valid", OUT_VALID, exp_ov);
            if (exp_ov) begin
                chk("result",  RESULT,            q[0].r.res);
                chk("special", RESULT_IS_SPECIAL, q[0].r.spec);
                chk("fp_exce", FP_EXCE,           q[0].r.exc);
            end
            if (m_after_rst) begin
                chk("rst_result",  RESULT,            8'h00);
                chk("rst_special", RESULT_IS_SPECIAL, 1'b0);
                chk("rst_exce",    FP_EXCE,           3'b000);
            end
            chk("status",    STATUS,    m_status);
            chk("exc_count", EXC_COUNT, m_count);
        end
        IN_VALID     = v;
        FP_OPERATION = op;
        OP_A         = a;
        OP_B         = b;
        OUT_READY    = ordy;
        STATUS_CLR   = clr;
        RST          = rst;
        #1;
        if (rst) begin
            if (m_valid) chk("in_ready_rst", IN_READY, 1'b0);
            q.delete();
            m_status    = 0;
            m_count     = 0;
            m_valid     = 1'b1;
            m_after_rst = 1'b1;
        end else if (m_valid) begin
            exp_ov = (q.size() > 0) && (q[0].age >= 1);
            exp_ir = (q.size() < 2) || ordy;
            chk("in_ready", IN_READY, exp_ir);
            xfer = exp_ov && ordy;
            acc  = v && exp_ir;
            if (clr) begin
                m_status = 0;
                m_count  = 0;
            end
            if (xfer) begin
                e = q.pop_front();
                m_status = m_status | int'(e.r.exc);
                if (e.r.exc != 3'b000 && m_count < 255) m_count++;
            end
            foreach (q[i]) q[i].age = q[i].age + 1;
            if (acc) begin
                e.r   = resolve(op, a, b);
                e.age = 0;
                q.push_back(e);
            end
            m_after_rst = 1'b0;
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'b00, 8'h00, 8'h00, ordy, 1'b0, 1'b0);
    endtask

    // Issue one request with OUT_READY high; returns while its result is visible
    task automatic run_one(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        step(1'b1, op, a, b, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic expect_lit(input string name, input logic [7:0] r, input logic s, input logic [2:0] x);
        chk({name, "_valid"},   OUT_VALID,         1'b1);
        chk({name, "_result"},  RESULT,            r);
        chk({name, "_special"}, RESULT_IS_SPECIAL, s);
        chk({name, "_exce"},    FP_EXCE,           x);
    endtask

    function automatic logic [7:0] rand_operand();
        logic [7:0] x;
        x = 8'($urandom());
        case ($urandom_range(0, 9))
            0: x = 8'h78;
            1: x = 8'hF8;
            2: x = 8'h00;
            3: x = 8'h80;
            4: x = {x[7], 4'hF, (x[2:0] == 3'd0) ? 3'd1 : x[2:0]};
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        // Pin the model against hand-computed results
        chk("pin_add_inv",  resolve(c_ADD, 8'h78, 8'hF8), {8'h7C, 1'b1, 3'b001});
        chk("pin_sub_inf",  resolve(c_SUB, 8'h38, 8'h78), {8'hF8, 1'b1, 3'b100});
        chk("pin_mul_zero", resolve(c_MUL, 8'h80, 8'h38), {8'h80, 1'b1, 3'b000});
        chk("pin_rsv_nan",  resolve(c_RSV, 8'h7D, 8'h78), {8'h00, 1'b0, 3'b000});
        chk("pin_sub_aInf", resolve(c_SUB, 8'hF8, 8'h78), {8'hF8, 1'b1, 3'b100});

        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk("ready_after_rst", IN_READY, 1'b1);

        // Directed cases with literal expectations
        run_one(c_ADD, 8'h78, 8'hF8);
        expect_lit("add_inf_inv", 8'h7C, 1'b1, 3'b001);
        idle(1'b1);
        chk("status_after_add", STATUS, 3'b001);
        chk("count_after_add",  EXC_COUNT, 8'd1);

        run_one(c_MUL, 8'h00, 8'hF8);
        expect_lit("mul_zero_inf", 8'h7C, 1'b1, 3'b001);
        run_one(c_MUL, 8'h80, 8'h38);
        expect_lit("mul_neg_zero", 8'h80, 1'b1, 3'b000);
        idle(1'b1);
        chk("count_after_mul0", EXC_COUNT, 8'd2);

        run_one(c_SUB, 8'h38, 8'h78);
        expect_lit("sub_b_inf", 8'hF8, 1'b1, 3'b100);
        run_one(c_SUB, 8'h7D, 8'h38);
        expect_lit("sub_nan", 8'h7C, 1'b1, 3'b010);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: two accepts fill the pipe, then IN_READY drops
        step(1'b1, c_MUL, 8'h78, 8'hB8, 1'b0, 1'b0, 1'b0);
        step(1'b1, c_ADD, 8'h7E, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, c_SUB, 8'h78, 8'h78, 1'b0, 1'b0, 1'b0);
        chk("stall_in_ready", IN_READY, 1'b0);
        step(1'b1, c_SUB, 8'h78, 8'h78, 1'b1, 1'b0, 1'b0);
        step(1'b1, c_MUL, 8'h00, 8'h90, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("stall_drained", q.size(), 0);

        // Counter saturation
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, c_ADD, 8'h7F, 8'h10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("count_saturated", EXC_COUNT, 8'hFF);
        chk("status_nan_only", STATUS, 3'b010);

        // Clear coinciding with an INF transfer
        step(1'b1, c_MUL, 8'h78, 8'h38, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        chk("clr_xfer_status", STATUS, 3'b100);
        chk("clr_xfer_count",  EXC_COUNT, 8'd1);

        // Reset with both stages full discards everything in flight
        step(1'b1, c_ADD, 8'h78, 8'h38, 1'b0, 1'b0, 1'b0);
        step(1'b1, c_SUB, 8'hF8, 8'h38, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        chk("rst_full_out_valid", OUT_VALID, 1'b0);
        chk("rst_full_in_ready",  IN_READY, 1'b1);
        chk("rst_full_status",    STATUS, 3'b000);
        chk("rst_full_count",     EXC_COUNT, 8'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Randomized traffic with random backpressure, clears and resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 2'($urandom()), rand_operand(), rand_operand(),
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
